store_unit: RTL

- Memory-side consumer of the store control word from the S-type decoder: we_mem plus the memdata_width code (3'b100 sb, 3'b011 sh, 3'b010 sw).
- Accepts store requests from the EX/MEM stage and converts each into a word-aligned address, a lane-replicated data word and a byte-write mask.
- Queues requests in a small in-order FIFO and issues them to the data-memory write port over a valid/ready handshake.
- Back-pressures the pipeline when the FIFO is full.

---
 rtl/store_unit_if.sv | 33 +++
 rtl/store_unit.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/store_unit_if.sv
// -----------------------------------------------------------------------------
// store_unit_if : request and memory-write bundle for store_unit.
//
//   Request side   : in_valid, in_ready, in_width, in_addr, in_data
//   Memory side    : mem_valid, mem_ready, mem_addr, mem_wdata, mem_wmask
//
// modport slave  : the store unit (consumes requests, drives the memory port)
// modport master : the environment (EX/MEM stage driving requests plus the
//                  data memory answering with mem_ready)
// -----------------------------------------------------------------------------
interface store_unit_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_width;
    logic [31:0] in_addr;
    logic [31:0] in_data;

    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;

    modport master (
        output in_valid, in_width, in_addr, in_data, mem_ready,
        input  in_ready, mem_valid, mem_addr, mem_wdata, mem_wmask
    );

    modport slave (
        input  in_valid, in_width, in_addr, in_data, mem_ready,
        output in_ready, mem_valid, mem_addr, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/store_unit.sv
// -----------------------------------------------------------------------------
// store_unit : buffers S-type store requests and issues them to the data
// memory write port.
//
// Each accepted request is formatted at accept time (word address, byte
// lanes replicated, byte-write mask) and pushed into an in-order FIFO of
// DEPTH entries. The head entry is presented on the memory port with a
// valid/ready handshake.
//
// Ports
//   clk, rst     : clock, synchronous active-high reset
//   bus (slave)  : request handshake (in_*) and memory write port (mem_*)
//   count        : entries currently buffered
//   busy         : count != 0
//   fault        : one-cycle pulse after a misaligned store is accepted
//   fault_addr   : byte address of the most recent faulting store
//
// Build option
//   MISALIGN_TRAP_EN : defined   -> misaligned sh/sw are dropped and trapped
//                      undefined -> misaligned sh/sw are forced aligned,
//                                   fault/fault_addr tied to 0
// -----------------------------------------------------------------------------
module store_unit #(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    store_unit_if.slave              bus,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy,
    output logic                     fault,
    output logic [31:0]              fault_addr
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    localparam logic [2:0] W_SB = 3'b100;
    localparam logic [2:0] W_SH = 3'b011;
    localparam logic [2:0] W_SW = 3'b010;

    // FIFO bookkeeping
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;

    // Pre-formatted entries; no reset needed, occupancy is tracked by count_q
    logic [29:0] addr_q  [DEPTH];
    logic [31:0] wdata_q [DEPTH];
    logic [3:0]  mask_q  [DEPTH];

    logic        is_sb, is_sh, is_sw, width_ok;
    logic        accept, push, pop;
    logic [3:0]  fmt_mask;
    logic [31:0] fmt_wdata;

    assign is_sb    = (bus.in_width == W_SB);
    assign is_sh    = (bus.in_width == W_SH);
    assign is_sw    = (bus.in_width == W_SW);
    assign width_ok = is_sb | is_sh | is_sw;

    // Readiness depends only on registered occupancy: no pop-to-push bypass
    assign bus.in_ready  = (count_q != FULL);
    assign bus.mem_valid = (count_q != '0);
    assign accept        = bus.in_valid & bus.in_ready;
    assign pop           = bus.mem_valid & bus.mem_ready;

    // Lane formatting. The sh mask looks only at addr[1] and the sw mask is
    // constant, so a misaligned request is already forced aligned here.
    always_comb begin
        fmt_mask  = 4'b0000;
        fmt_wdata = bus.in_data;
        if (is_sb) begin
            fmt_mask  = 4'b0001 << bus.in_addr[1:0];
            fmt_wdata = {4{bus.in_data[7:0]}};
        end else if (is_sh) begin
            fmt_mask  = 4'b0011 << {bus.in_addr[1], 1'b0};
            fmt_wdata = {2{bus.in_data[15:0]}};
        end else if (is_sw) begin
            fmt_mask  = 4'b1111;
            fmt_wdata = bus.in_data;
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic        misalign;
    logic        fault_q, fault_d;
    logic [31:0] fault_addr_q, fault_addr_d;

    assign misalign = (is_sh & bus.in_addr[0]) | (is_sw & (bus.in_addr[1:0] != 2'b00));
    // Misaligned stores complete the handshake but never reach the FIFO
    assign push     = accept & width_ok & ~misalign;

    always_comb begin
        fault_d      = accept & misalign;
        fault_addr_d = fault_addr_q;
        if (accept & misalign) fault_addr_d = bus.in_addr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
        end else begin
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
        end
    end

    assign fault      = fault_q;
    assign fault_addr = fault_addr_q;
`else
    assign push       = accept & width_ok;
    assign fault      = 1'b0;
    assign fault_addr = '0;
`endif

    // Pointers wrap naturally because DEPTH is a power of two
    always_comb begin
        count_d  = count_q + CW'(push) - CW'(pop);
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr_q]  <= bus.in_addr[31:2];
            wdata_q[wr_ptr_q] <= fmt_wdata;
            mask_q[wr_ptr_q]  <= fmt_mask;
        end
    end

    assign bus.mem_addr  = {addr_q[rd_ptr_q], 2'b00};
    assign bus.mem_wdata = wdata_q[rd_ptr_q];
    assign bus.mem_wmask = mask_q[rd_ptr_q];

    assign count = count_q;
    assign busy  = (count_q != '0);
endmodule
